// File: rtl/onfi_pkg.sv
// Shared types and sizes for the ONFI feature-read capture path.
// Holds the capture FSM state encoding and feature word geometry.
package onfi_pkg;

  localparam int FEATURE_BYTES = 4;
  localparam int FEATURE_W     = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_HOLD
  } state_t;

endpackage

// File: rtl/feature_rx_if.sv
// Feature word output stream: data/data_valid from the receiver,
// data_ready from the consumer. master = receiver, slave = consumer.
interface feature_rx_if;
  import onfi_pkg::*;

  logic [FEATURE_W-1:0] data;
  logic                 data_valid;
  logic                 data_ready;

  modport master (
    output data,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/onfi_sync_edge.sv
// Synchronizes DQS and DQ through equal-depth flop chains and flags
// every DQS transition. Ports: clk/rst, i_dqs, i_dq -> o_edge, o_dq.
module onfi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_dqs,
  input  logic [7:0] i_dq,
  output logic       o_edge,
  output logic [7:0] o_dq
);

  logic [SYNC_STAGES-1:0]      r_dqs_sync;
  logic [SYNC_STAGES-1:0][7:0] r_dq_sync;
  logic                        r_dqs_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dqs_sync <= '0;
      r_dq_sync  <= '0;
      r_dqs_prev <= 1'b0;
    end else begin
      r_dqs_sync[0] <= i_dqs;
      r_dq_sync[0]  <= i_dq;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_dqs_sync[i] <= r_dqs_sync[i-1];
        r_dq_sync[i]  <= r_dq_sync[i-1];
      end
      r_dqs_prev <= r_dqs_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_dqs_sync[SYNC_STAGES-1] ^ r_dqs_prev;
  assign o_dq   = r_dq_sync[SYNC_STAGES-1];

endmodule

// File: rtl/feature_rx.sv
// ONFI GET FEATURES receiver: captures 4 DQS-strobed bytes into a
// 32-bit word. Ports: onfi_clk/onfi_rst, start, onfi_dq/onfi_dqs in;
// busy, timeout out; rx (master) carries data/data_valid/data_ready.
module feature_rx
  import onfi_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic         onfi_clk,
  input  logic         onfi_rst,
  input  logic         start,
  input  logic [7:0]   onfi_dq,
  input  logic         onfi_dqs,
  output logic         busy,
  output logic         timeout,
  feature_rx_if.master rx
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC);
  localparam logic [1:0]    LAST_BYTE = 2'(FEATURE_BYTES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [FEATURE_W-1:0] r_data;
  logic [1:0]           r_cnt;
  logic [TW-1:0]        r_tmo;

  logic       w_edge;
  logic [7:0] w_dq;
  logic       w_arm;
  logic       w_cap;
  logic       w_expire;

  onfi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (onfi_clk),
    .rst    (onfi_rst),
    .i_dqs  (onfi_dqs),
    .i_dq   (onfi_dq),
    .o_edge (w_edge),
    .o_dq   (w_dq)
  );

  always_ff @(posedge onfi_clk or posedge onfi_rst) begin
    if (onfi_rst) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_cap       = 1'b0;
    w_expire    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ARM;
          w_arm       = 1'b1;
        end
      end
      S_ARM: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        // an edge wins over an expiry landing in the same cycle
        if (w_edge) begin
          w_cap = 1'b1;
          if (r_cnt == LAST_BYTE) w_state_nxt = S_HOLD;
        end else if (r_tmo <= TW'(1)) begin
          w_expire    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (rx.data_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge onfi_clk or posedge onfi_rst) begin
    if (onfi_rst) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_tmo  <= '0;
    end else if (w_arm) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_tmo  <= TMO_LOAD;
    end else if (w_cap) begin
      r_data[{r_cnt, 3'b000} +: 8] <= w_dq;
      r_cnt <= r_cnt + 2'd1;
      r_tmo <= TMO_LOAD;
    end else if (r_state == S_CAPTURE && r_tmo != '0) begin
      r_tmo <= r_tmo - TW'(1);
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign timeout       = w_expire;
  assign rx.data       = r_data;
  assign rx.data_valid = (r_state == S_HOLD);

endmodule
